flex_down_timer: RTL and testbench

FLEX_DOWN_TIMER -- requirements
Module: flex_down_timer

---
 rtl/flex_timer_pkg.sv | 11 +
 rtl/flex_prescaler.sv | 39 +++
 rtl/flex_down_timer.sv | 138 +++++++++++++
 tb/tb_flex_down_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/flex_timer_pkg.sv
// Shared definitions for the flex down-timer.
//   timer_state_t : controller state encoding (IDLE, RUN, EXPIRE)
package flex_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/flex_prescaler.sv
// Tick prescaler for the flex down-timer.
// Emits one strobe every (prescale_val+1) cycles in which enable is high.
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous zeroing of the prescale count
//   enable        : qualifies counting (paused when low)
//   prescale_val  : divide ratio minus one
//   strobe        : combinational, high on the enabled cycle that completes a period
module flex_prescaler #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] prescale_val,
  output logic             strobe
);

  logic [WIDTH-1:0] pre_cnt;

  // >= rather than == so a ratio lowered mid-count cannot miss its terminal value
  assign strobe = enable && (pre_cnt >= prescale_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      if (pre_cnt >= prescale_val) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/flex_down_timer.sv
// Loadable down-counting timer with one-shot / periodic modes.
// Optional feature macro: FLEX_TIMER_PRESCALE_EN (adds prescale_val and a
// tick prescaler; when undefined every tick_enable cycle decrements).
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous abort to IDLE (highest priority)
//   load_valid    : load request; accepted when load_ready is high
//   load_ready    : high when not RUN and not clearing
//   load_val      : start / reload tick count
//   periodic      : auto-reload (1) or one-shot (0), sampled at accept
//   tick_enable   : decrement qualifier; low pauses the count
//   prescale_val  : (FLEX_TIMER_PRESCALE_EN only) strobe every prescale_val+1 ticks
//   count_out     : remaining ticks (registered)
//   expire_flag   : single-cycle expiry pulse (registered)
//   busy          : high while in RUN
module flex_down_timer
  import flex_timer_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS  = 4,
  parameter int unsigned PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     periodic,
  input  logic                     tick_enable,
`ifdef FLEX_TIMER_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     expire_flag,
  output logic                     busy
);

  timer_state_t             state, state_next;
  logic [NUM_CNT_BITS-1:0]  reload, reload_next;
  logic [NUM_CNT_BITS-1:0]  count_next;
  logic                     periodic_q, periodic_next;
  logic                     expire_next;
  logic                     accept;
  logic                     dec;

  assign load_ready = (state != RUN) && !clear;
  assign accept     = load_valid && load_ready;
  assign busy       = (state == RUN);

`ifdef FLEX_TIMER_PRESCALE_EN
  flex_prescaler #(
    .WIDTH (PRESCALE_BITS)
  ) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear || accept),
    .enable       (tick_enable && (state == RUN)),
    .prescale_val (prescale_val),
    .strobe       (dec)
  );
`else
  logic [PRESCALE_BITS-1:0] prescale_unused;
  assign prescale_unused = '0;
  assign dec             = tick_enable;
`endif

  always_comb begin
    state_next    = state;
    count_next    = count_out;
    reload_next   = reload;
    periodic_next = periodic_q;
    expire_next   = 1'b0;

    if (clear) begin
      state_next    = IDLE;
      count_next    = '0;
      reload_next   = '0;
      periodic_next = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dec) begin
            if (count_out > NUM_CNT_BITS'(1)) begin
              count_next = count_out - NUM_CNT_BITS'(1);
            end else begin
              expire_next = 1'b1;
              if (periodic_q) begin
                count_next = reload;
              end else begin
                count_next = '0;
                state_next = EXPIRE;
              end
            end
          end
        end
        IDLE, EXPIRE: begin
          state_next = IDLE;
          if (accept) begin
            if (load_val == '0) begin
              // zero-length load expires immediately; periodic is meaningless here
              count_next    = '0;
              reload_next   = '0;
              periodic_next = 1'b0;
              expire_next   = 1'b1;
              state_next    = EXPIRE;
            end else begin
              count_next    = load_val;
              reload_next   = load_val;
              periodic_next = periodic;
              state_next    = RUN;
            end
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      count_out   <= '0;
      reload      <= '0;
      periodic_q  <= 1'b0;
      expire_flag <= 1'b0;
    end else begin
      state       <= state_next;
      count_out   <= count_next;
      reload      <= reload_next;
      periodic_q  <= periodic_next;
      expire_flag <= expire_next;
    end
  end

endmodule

// File: tb/tb_flex_down_timer.sv
module tb_flex_down_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_val;
  logic       periodic;
  logic       tick_enable;
  logic [3:0] count_out;
  logic       expire_flag;
  logic       busy;
`ifdef FLEX_TIMER_PRESCALE_EN
  logic [3:0] prescale_val;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       lv;
    logic [3:0] val;
    logic       per;
    logic       te;
    logic       clr;
    logic [3:0] cnt;
    logic       expf;
    logic       bsy;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  flex_down_timer #(
    .NUM_CNT_BITS  (4),
    .PRESCALE_BITS (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_val    (load_val),
    .periodic    (periodic),
    .tick_enable (tick_enable),
`ifdef FLEX_TIMER_PRESCALE_EN
    .prescale_val(prescale_val),
`endif
    .count_out   (count_out),
    .expire_flag (expire_flag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic lv, int val, logic per, logic te, logic clr,
                              int cnt, logic expf, logic bsy, logic rdy);
    vec_t v;
    v.lv = lv; v.val = 4'(val); v.per = per; v.te = te; v.clr = clr;
    v.cnt = 4'(cnt); v.expf = expf; v.bsy = bsy; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(string tag, vec_t v);
    vec_t e;
    @(negedge clk);
    load_valid  = v.lv;
    load_val    = v.val;
    periodic    = v.per;
    tick_enable = v.te;
    clear       = v.clr;
    expq.push_back(v);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    chk({tag, ".count"},  int'(count_out),   int'(e.cnt));
    chk({tag, ".expire"}, int'(expire_flag), int'(e.expf));
    chk({tag, ".busy"},   int'(busy),        int'(e.bsy));
    chk({tag, ".ready"},  int'(load_ready),  int'(e.rdy));
  endtask

  initial begin
    // one-shot 3
    vecs.push_back(mk(1, 3, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // periodic 2 over 6 ticks, then clear
    vecs.push_back(mk(1, 2, 1, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // load 4 with a 5-cycle pause
    vecs.push_back(mk(1, 4, 0, 1, 0, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // load 0 (periodic ignored)
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // load during RUN ignored, then back-to-back load in EXPIRE
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 2, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));

    n_rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_val = '0;
    periodic = 1'b0; tick_enable = 1'b0;
`ifdef FLEX_TIMER_PRESCALE_EN
    prescale_val = '0;
`endif
    #1;
    chk("reset.count",  int'(count_out),   0);
    chk("reset.expire", int'(expire_flag), 0);
    chk("reset.busy",   int'(busy),        0);
    chk("reset.ready",  int'(load_ready),  1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // clear while count_out==1 and ticking: pulse suppressed
    step("clr0", mk(1, 2, 0, 1, 0, 2, 0, 1, 0));
    step("clr1", mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    step("clr2", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    step("clr3", mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    step("clr4", mk(0, 0, 0, 1, 0, 0, 0, 0, 1));

    // asynchronous reset while count_out==1 and ticking
    step("rst0", mk(1, 2, 0, 1, 0, 2, 0, 1, 0));
    step("rst1", mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    @(negedge clk);
    tick_enable = 1'b1;
    n_rst = 1'b0;
    #1;
    chk("rst_async.count",  int'(count_out),   0);
    chk("rst_async.expire", int'(expire_flag), 0);
    chk("rst_async.busy",   int'(busy),        0);
    chk("rst_async.ready",  int'(load_ready),  1);
    @(posedge clk);
    #1;
    chk("rst_held.expire", int'(expire_flag), 0);
    chk("rst_held.count",  int'(count_out),   0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel.expire", int'(expire_flag), 0);
    chk("rst_rel.busy",   int'(busy),        0);
    chk("rst_rel.ready",  int'(load_ready),  1);

`ifdef FLEX_TIMER_PRESCALE_EN
    // prescale 2, load 2: decrements on every 3rd enabled cycle, expiry after 6
    prescale_val = 4'd2;
    step("pre0", mk(1, 2, 0, 1, 0, 2, 0, 1, 0));
    step("pre1", mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    step("pre2", mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    step("pre3", mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    step("pre4", mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    step("pre5", mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    step("pre6", mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    step("pre7", mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    prescale_val = '0;
`endif

    chk("scoreboard.empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
